adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 8, operand width per input.
REQ-002 SHALL have parameter WIDTH_OUT, default 9, sum width; WIDTH_OUT = WIDTH_IN+1.
REQ-003 SHALL have parameter NREQ, default 4, number of requesters; NREQ is a power of two, 2..8.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operand-valid.
REQ-007 SHALL have port req_a  input  NREQ*WIDTH_IN  packed operand A; requester i occupies slice i.
REQ-008 SHALL have port req_b  input  NREQ*WIDTH_IN  packed operand B; requester i occupies slice i.
REQ-009 SHALL have port req_ready  output  NREQ  one-hot-or-zero grant/accept.
REQ-010 SHALL have port rsp_valid  output  1  result register holds a valid sum.
REQ-011 SHALL have port rsp_sum  output  WIDTH_OUT  unsigned a+b of the granted request.
REQ-012 SHALL have port rsp_id  output  log2(NREQ)  index of the requester owning rsp_sum.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port grant_count  output  16  total accepted requests since reset, saturating.

Function
REQ-015 SHALL share one combinational adder among all requesters; the adder sees only the granted slice.
REQ-016 SHALL keep a one-entry output register with states EMPTY and FULL.
REQ-017 SHALL define can_accept = EMPTY, or (FULL and rsp_ready).
REQ-018 SHALL select the granted requester round-robin: search starts at pointer ptr and goes upward modulo NREQ; the first asserted req_valid wins.
REQ-019 SHALL drive req_ready[g]=1 combinationally for winner g only when can_accept; else all zeros.
REQ-020 SHALL complete a transfer in a cycle where req_valid[g] and req_ready[g] are both high.
REQ-021 SHALL, on a transfer, load rsp_sum=a_g+b_g zero-extended to WIDTH_OUT, load rsp_id=g, and enter FULL at the next edge (latency 1 cycle).
REQ-022 SHALL set ptr=(g+1) mod NREQ after a transfer; ptr is unchanged otherwise.
REQ-023 SHALL, when FULL and rsp_ready is high with no new transfer, go to EMPTY.
REQ-024 SHALL, when FULL and rsp_ready is high with a simultaneous transfer, stay FULL with the new result (throughput 1/cycle).
REQ-025 SHALL, when FULL and rsp_ready is low, hold rsp_sum and rsp_id stable and grant nobody.
REQ-026 SHALL give rsp_valid=1 exactly in state FULL.
REQ-027 SHALL increment grant_count on each transfer and hold it at 16'hFFFF once reached.
REQ-028 SHALL ignore req_a/req_b of non-granted requesters; a requester keeps valid and data stable until its ready.

Reset
REQ-029 SHALL, on a clock edge with reset low, set state=EMPTY, rsp_valid=0, rsp_sum=0, rsp_id=0, ptr=0, grant_count=0.
REQ-030 SHALL, on reset mid-operation, discard any held result without presenting it; req_ready=0 while reset is low.

Structure
REQ-031 SHALL take WIDTH_IN/WIDTH_OUT defaults and the EMPTY/FULL state enum from shared package adder_pkg.
REQ-032 SHALL instantiate the existing adder module as its single sub-module for the sum.

Verification
REQ-033 SHALL cover a single request: req_valid=0001, a=8'd200, b=8'd100 -> next cycle rsp_valid=1, rsp_sum=9'd300, rsp_id=0, grant_count=1.
REQ-034 SHALL cover round-robin: all four req_valid held high with rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles.
REQ-035 SHALL cover backpressure: FULL with rsp_ready=0 for 3 cycles -> req_ready=0000, rsp_sum/rsp_id unchanged; rsp_ready=1 -> grant in the same cycle.
REQ-036 SHALL cover overflow: a=8'hFF, b=8'hFF -> rsp_sum=9'h1FE.
REQ-037 SHALL cover reset while FULL -> rsp_valid=0, ptr=0 and grant_count=0 next cycle; the next grant goes to the lowest valid requester.
REQ-038 SHALL check every response against a reference sum, flag any mismatch, and report the total error count at the end.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and types for the adder datapath and its front-end arbiter.
package adder_pkg;

  localparam int unsigned WidthInDefault  = 8;
  localparam int unsigned WidthOutDefault = WidthInDefault + 1;
  localparam int unsigned CountW          = 16;

  // Occupancy of the one-entry result register.
  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

endpackage

// File: rtl/adder.sv
// Unsigned combinational adder; the sum is zero-extended to the output width.
module adder #(
  parameter int unsigned WIDTH_IN  = adder_pkg::WidthInDefault,
  parameter int unsigned WIDTH_OUT = adder_pkg::WidthOutDefault
) (
  input  logic [WIDTH_IN-1:0]  a_i,
  input  logic [WIDTH_IN-1:0]  b_i,
  output logic [WIDTH_OUT-1:0] sum_o
);

  assign sum_o = WIDTH_OUT'(a_i) + WIDTH_OUT'(b_i);

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of a single shared adder, with a one-entry
// result register and a saturating count of accepted requests.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = WidthInDefault,
  parameter int unsigned WIDTH_OUT = WidthOutDefault,
  parameter int unsigned NREQ      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH_IN-1:0]  req_a,
  input  logic [NREQ*WIDTH_IN-1:0]  req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [WIDTH_OUT-1:0]      rsp_sum,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  input  logic                      rsp_ready,
  output logic [CountW-1:0]         grant_count
);

  localparam int unsigned IdW      = $clog2(NREQ);
  localparam logic [CountW-1:0] CountMax = '1;

  state_e               state_q, state_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [WIDTH_OUT-1:0] sum_q, sum_d;
  logic [IdW-1:0]       id_q, id_d;
  logic [CountW-1:0]    cnt_q, cnt_d;

  logic                 gnt_found;
  logic [IdW-1:0]       gnt_idx;
  logic [IdW-1:0]       cand;
  logic                 can_accept;
  logic                 xfer;
  logic [WIDTH_IN-1:0]  sel_a, sel_b;
  logic [WIDTH_OUT-1:0] add_sum;

  // Search upward from ptr_q; IdW-bit wrap gives the modulo since NREQ is 2^IdW.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ptr_q + IdW'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Holding reset low also blocks acceptance so nothing is granted during reset.
  assign can_accept = reset && ((state_q == StEmpty) || rsp_ready);
  assign xfer       = gnt_found && can_accept;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign sel_a = req_a[gnt_idx*WIDTH_IN +: WIDTH_IN];
  assign sel_b = req_b[gnt_idx*WIDTH_IN +: WIDTH_IN];

  adder #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) u_adder (
    .a_i   (sel_a),
    .b_i   (sel_b),
    .sum_o (add_sum)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      state_d = StFull;
      ptr_d   = gnt_idx + IdW'(1);
      sum_d   = add_sum;
      id_d    = gnt_idx;
      if (cnt_q != CountMax) begin
        cnt_d = cnt_q + CountW'(1);
      end
    end else if ((state_q == StFull) && rsp_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      sum_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid   = (state_q == StFull);
  assign rsp_sum     = sum_q;
  assign rsp_id      = id_q;
  assign grant_count = cnt_q;

endmodule
